// File: rtl/logic_gate_pkg.sv
// Shared opcode definitions for the logic gate pipeline and its combinational ALU.
package logic_gate_pkg;

    localparam int LOGIC_OP_W = 3;

    typedef enum logic [LOGIC_OP_W-1:0] {
        OP_NAND = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_PASS = 3'd7
    } logic_op_e;

endpackage

// File: rtl/logic_gate_alu.sv
// Purely combinational bitwise operation decode: Y = OP(A, B) across WIDTH bits.
module logic_gate_alu
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [LOGIC_OP_W-1:0] OP,
    output logic [WIDTH-1:0]      Y
);

    always_comb begin
        Y = '0;
        case (logic_op_e'(OP))
            OP_NAND: Y = ~(A & B);
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_NOR:  Y = ~(A | B);
            OP_XOR:  Y = A ^ B;
            OP_XNOR: Y = ~(A ^ B);
            OP_NOT:  Y = ~A;
            OP_PASS: Y = A;
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Bitwise logic unit with a 2-entry result FIFO, registered result flags and a
// saturating count of accepted operations.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      A,
    input  logic [WIDTH-1:0]      B,
    input  logic [LOGIC_OP_W-1:0] OP,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      C,
    output logic                  ZERO,
    output logic                  ONES,
    output logic                  PARITY,
    output logic [CNT_W-1:0]      op_count
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and in_ready depends only on the
    // registered occupancy (never on out_ready), so a full FIFO refuses input
    // even when it is being popped in the same cycle.

    localparam int ENT_W = WIDTH + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] alu_y;
    logic [ENT_W-1:0] ent_mem [2];
    logic [ENT_W-1:0] new_ent;
    logic [ENT_W-1:0] head;
    logic [1:0]       occ;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
        .A  (A),
        .B  (B),
        .OP (OP),
        .Y  (alu_y)
    );

    // Flags are captured alongside the result so they describe the stored value.
    assign new_ent = {^alu_y, &alu_y, ~|alu_y, alu_y};

    assign in_ready  = rst_n && (occ < 2'd2);
    assign out_valid = (occ != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            op_count <= '0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && (op_count != CNT_MAX)) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is visible unless occupancy says so.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_mem[wr_ptr] <= new_ent;
        end
    end

    assign head   = ent_mem[rd_ptr];
    assign C      = out_valid ? head[WIDTH-1:0] : '0;
    assign ZERO   = out_valid && head[WIDTH];
    assign ONES   = out_valid && head[WIDTH+1];
    assign PARITY = out_valid && head[WIDTH+2];

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Bench for logic_gate_pipe: directed cases plus random traffic, scored against a
// queue-based model of the result FIFO and the opcode truth table.
module tb_logic_gate_pipe;

    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;

    logic             in_ready, out_valid, zero, ones, parity;
    logic [WIDTH-1:0] c;
    logic [15:0]      op_count;

    logic             s_in_ready, s_out_valid, s_zero, s_ones, s_parity;
    logic [WIDTH-1:0] s_c;
    logic [3:0]       s_op_count;

    logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .OP(op), .out_valid(out_valid), .out_ready(out_ready),
        .C(c), .ZERO(zero), .ONES(ones), .PARITY(parity), .op_count(op_count)
    );

    logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .A(a), .B(b), .OP(op), .out_valid(s_out_valid), .out_ready(out_ready),
        .C(s_c), .ZERO(s_zero), .ONES(s_ones), .PARITY(s_parity), .op_count(s_op_count)
    );

    // ---------------- scoreboard / model ----------------
    logic [WIDTH-1:0] exp_q[$];
    int               n_acc = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    function automatic logic [WIDTH-1:0] ref_op(input int o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (o)
            0: r = ~(x & y);
            1: r = x & y;
            2: r = x | y;
            3: r = ~(x | y);
            4: r = x ^ y;
            5: r = ~(x ^ y);
            6: r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        logic             v;
        logic [WIDTH-1:0] h;
        int               cnt;
        v   = (exp_q.size() > 0);
        h   = v ? exp_q[0] : '0;
        cnt = n_acc;
        check("out_valid", 64'(out_valid), 64'(v));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
        check("c", 64'(c), 64'(h));
        check("zero", 64'(zero), 64'(v && (h == 0)));
        check("ones", 64'(ones), 64'(v && (h == 8'hFF)));
        check("parity", 64'(parity), 64'(v && ($countones(h) % 2 == 1)));
        check("op_count", 64'(op_count), 64'((cnt > 65535) ? 65535 : cnt));
        check("sat_count", 64'(s_op_count), 64'((cnt > 15) ? 15 : cnt));
        check("sat_c", 64'(s_c), 64'(h));
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; checks, drives one cycle, updates the model and
    // returns at the next falling edge.
    task automatic step(input logic v, input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                        input int oo, input logic rdy);
        logic acc, pp;
        check_outputs();
        in_valid  = v;
        a         = aa;
        b         = bb;
        op        = 3'(oo);
        out_ready = rdy;
        acc = v && (exp_q.size() < 2);
        pp  = (exp_q.size() > 0) && rdy;
        @(posedge clk);
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
            exp_q.push_back(ref_op(oo, aa, bb));
            n_acc++;
        end
        @(negedge clk);
    endtask

    logic [WIDTH-1:0] sweep_tab [8];

    initial begin
        sweep_tab = '{8'hF5, 8'h0A, 8'hAF, 8'h50, 8'hA5, 8'h5A, 8'h55, 8'hAA};
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;

        // reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_c", 64'(c), 64'(0));
        check("rst_flags", 64'({zero, ones, parity}), 64'(0));
        check("rst_op_count", 64'(op_count), 64'(0));
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'(1));

        // NAND example
        step(1'b1, 8'hF0, 8'hCC, 0, 1'b1);
        check("nand_c", 64'(c), 64'(8'h3F));
        check("nand_flags", 64'({zero, ones, parity}), 64'(0));
        check("nand_count", 64'(op_count), 64'(1));

        // opcode sweep, each cycle pushes and pops at occupancy 1
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 8'hAA, 8'h0F, k, 1'b1);
            check("sweep_c", 64'(c), 64'(sweep_tab[k]));
        end
        step(1'b0, 8'h00, 8'h00, 0, 1'b1);

        // backpressure: third op held until space frees
        step(1'b1, 8'h11, 8'h22, 1, 1'b0);
        step(1'b1, 8'h33, 8'h44, 2, 1'b0);
        check("full_in_ready", 64'(in_ready), 64'(0));
        step(1'b1, 8'h55, 8'h66, 4, 1'b0);
        check("held_c", 64'(c), 64'(8'h00));
        step(1'b1, 8'h55, 8'h66, 4, 1'b1);
        check("drain2_c", 64'(c), 64'(8'h77));
        step(1'b1, 8'h55, 8'h66, 4, 1'b1);
        check("third_c", 64'(c), 64'(8'h33));
        step(1'b0, 8'h00, 8'h00, 0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 0, 1'b1);

        // random traffic with varying backpressure
        for (int i = 0; i < 400; i++) begin
            int rdy_pct;
            rdy_pct = (i < 150) ? 80 : ((i < 275) ? 30 : 60);
            step($urandom_range(0, 99) < 70, 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 7)), $urandom_range(0, 99) < rdy_pct);
        end

        // asynchronous reset with two entries buffered
        step(1'b1, 8'h0F, 8'hF0, 2, 1'b0);
        step(1'b1, 8'h00, 8'h00, 3, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_op_count", 64'(op_count), 64'(0));
        check("arst_sat_count", 64'(s_op_count), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(0));
        check("arst_c", 64'(c), 64'(0));
        exp_q.delete();
        n_acc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arel_in_ready", 64'(in_ready), 64'(1));
        check("arel_out_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        end
        check_outputs();

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width; legal range 1..64.
REQ-002 Parameter: CNT_W, default 16, width of transaction counter; legal range 4..32.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  operand/opcode presented.
REQ-006 Port: in_ready  output  1  block can accept an operand this cycle.
REQ-007 Port: A  input  WIDTH  operand A.
REQ-008 Port: B  input  WIDTH  operand B.
REQ-009 Port: OP  input  3  operation select, sampled with A/B.
REQ-010 Port: out_valid  output  1  result C and flags valid.
REQ-011 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-012 Port: C  output  WIDTH  bitwise result.
REQ-013 Port: ZERO  output  1  C is all zeros.
REQ-014 Port: ONES  output  1  C is all ones.
REQ-015 Port: PARITY  output  1  XOR-reduction of C.
REQ-016 Port: op_count  output  CNT_W  number of accepted operations, saturating.

Function
REQ-017 OP encoding: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A; all bitwise across WIDTH.
REQ-018 Accept occurs on an edge where in_valid=1 and in_ready=1; result plus flags written into a 2-entry output FIFO.
REQ-019 Latency: accepted result visible at C with out_valid=1 in the cycle after accept when FIFO was empty.
REQ-020 Pop occurs on an edge where out_valid=1 and out_ready=1; next entry (if any) presented the following cycle.
REQ-021 in_ready = (FIFO occupancy < 2), driven from registered occupancy only; no combinational path from out_ready to in_ready.
REQ-022 out_valid = (occupancy > 0); C/ZERO/ONES/PARITY SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous accept and pop at occupancy 1: occupancy stays 1, new result presented next cycle, order preserved.
REQ-024 At occupancy 2, in_valid is ignored (no accept) even if out_ready=1 that cycle.
REQ-025 Flags computed at accept time from the stored result, not from live inputs.
REQ-026 op_count increments by 1 per accept; at all-ones it SHALL remain all-ones (no wrap).
REQ-027 When out_valid=0, C and flags SHALL read 0.

Reset
REQ-028 rst_n=0 asynchronously clears FIFO occupancy, pointers, op_count; outputs: in_ready=0 during reset, 1 first cycle after release; out_valid=0, C=0, ZERO=0, ONES=0, PARITY=0, op_count=0.
REQ-029 Reset mid-operation discards all buffered results; no stale entry appears after release.

Structure
REQ-030 Shared package logic_gate_pkg holds the 3-bit opcode enum (OP_NAND..OP_PASS) and constant LOGIC_OP_W=3.
REQ-031 Combinational op decode is a sub-module logic_gate_alu (WIDTH param, A, B, OP in; Y out); FIFO and counter stay in logic_gate_pipe.

Verification
REQ-032 WIDTH=8, A=0xF0, B=0xCC, OP=0, out_ready=1 -> next cycle C=0x3F, ZERO=0, ONES=0, PARITY=0, op_count=1.
REQ-033 Sweep OP 0..7 with A=0xAA, B=0x0F -> C = 0xF5,0x0A,0xAF,0x50,0xA5,0x5A,0x55,0xAA in order.
REQ-034 out_ready=0, push three ops back-to-back -> in_ready drops after second accept, third held; releasing out_ready drains first two in order, then third accepted.
REQ-035 Occupancy 1, in_valid=1 and out_ready=1 same edge -> occupancy stays 1, next C is new result, no loss/duplication.
REQ-036 CNT_W=4, 20 accepts -> op_count reaches 0xF and stays 0xF.
REQ-037 Assert rst_n=0 asynchronously with 2 entries buffered -> out_valid=0, op_count=0 immediately; after release, in_ready=1, no stale output.
